// File: rtl/masked_sbox_pkg.sv
// Shared constants, share type and GF(2^8) helpers for the masked S-box lane array.
package masked_sbox_pkg;

   localparam int          SBOX_SHARES = 4;
   localparam int          SBOX_LAT    = 2;
   localparam int          LANE_RND_W  = 28;
   localparam logic [7:0]  AFFINE_C    = 8'h63;

   typedef logic [7:0] share_byte_t;

   // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic share_byte_t gf_mul(input share_byte_t a, input share_byte_t b);
      share_byte_t p;
      share_byte_t aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254, which is the field inverse for a != 0 and maps 0 to 0.
   function automatic share_byte_t gf_inv(input share_byte_t a);
      share_byte_t r;
      share_byte_t sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic share_byte_t aff_lin(input share_byte_t a);
      share_byte_t b;
      for (int i = 0; i < 8; i++)
         b[i] = a[i] ^ a[(i + 4) % 8] ^ a[(i + 5) % 8] ^ a[(i + 6) % 8] ^ a[(i + 7) % 8];
      return b;
   endfunction

endpackage

// File: rtl/masked_sbox_lane.sv
// One 4-share, two-register-stage S-box lane: stage 1 refreshes the shares within each
// domain, stage 2 holds the re-shared inverse, and the affine layer is applied per share.
module masked_sbox_lane
   import masked_sbox_pkg::*;
(
   input  logic                  clk_i,
   input  share_byte_t           sh_i [SBOX_SHARES],
   input  logic [LANE_RND_W-1:0] rnd_i,
   output share_byte_t           sh_o [SBOX_SHARES]
);

   share_byte_t s1_q [SBOX_SHARES];
   share_byte_t s2_q [SBOX_SHARES];
   share_byte_t s2_d [SBOX_SHARES];
   logic [11:0] r1_q;
   share_byte_t x_d, inv_d, ma, mb, mc;

   // NOTE: no reset on lane registers; the valid pipeline in the top decides which contents count.
   always_ff @(posedge clk_i) begin
      s1_q[0] <= sh_i[0] ^ rnd_i[7:0];
      s1_q[1] <= sh_i[1] ^ rnd_i[7:0];
      s1_q[2] <= sh_i[2] ^ rnd_i[15:8];
      s1_q[3] <= sh_i[3] ^ rnd_i[15:8];
      r1_q    <= rnd_i[27:16];
      s2_q    <= s2_d;
   end

   always_comb begin
      ma    = r1_q[7:0];
      mb    = {r1_q[11:8], r1_q[3:0]};
      mc    = {r1_q[7:4], r1_q[11:8]};
      x_d   = s1_q[0] ^ s1_q[1] ^ s1_q[2] ^ s1_q[3];
      inv_d = gf_inv(x_d);
      s2_d[0] = inv_d ^ ma;
      s2_d[1] = ma ^ mb;
      s2_d[2] = mb ^ mc;
      s2_d[3] = mc;
      // The affine map is linear, so it distributes over shares; the constant goes on share 0.
      for (int k = 0; k < SBOX_SHARES; k++)
         sh_o[k] = aff_lin(s2_q[k]) ^ ((k == 0) ? AFFINE_C : 8'h00);
   end

endmodule

// File: rtl/masked_sbox_lane_array.sv
// NUM_LANES masked S-box lanes behind one handshake, with a credit-checked output FIFO.
// Define OUT_ZEROIZE_EN to zero the outputs while empty and clear entries on pop.
module masked_sbox_lane_array
   import masked_sbox_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int RND_W      = LANE_RND_W
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [8*NUM_LANES-1:0]          in_sh0,
   input  logic [8*NUM_LANES-1:0]          in_sh1,
   input  logic [8*NUM_LANES-1:0]          in_sh2,
   input  logic [8*NUM_LANES-1:0]          in_sh3,
   input  logic                            rnd_valid,
   output logic                            rnd_ready,
   input  logic [RND_W*NUM_LANES-1:0]      rnd,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [8*NUM_LANES-1:0]          out_sh0,
   output logic [8*NUM_LANES-1:0]          out_sh1,
   output logic [8*NUM_LANES-1:0]          out_sh2,
   output logic [8*NUM_LANES-1:0]          out_sh3,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy,
   output logic                            busy
);

   localparam int W     = 8 * NUM_LANES;
   localparam int EW    = SBOX_SHARES * W;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int CW    = CNT_W + 1;

   typedef logic [EW-1:0] entry_t;

   logic [SBOX_LAT-1:0]      vpipe_q;
   logic [PTR_W-1:0]         wptr_q, rptr_q, prev_ptr;
   logic [CNT_W-1:0]         count_q;
   entry_t                   mem_q [FIFO_DEPTH];
   entry_t                   wr_entry, out_entry;
   logic [W-1:0]             sh_in    [SBOX_SHARES];
   logic [W-1:0]             sh_gated [SBOX_SHARES];
   logic [RND_W*NUM_LANES-1:0] rnd_gated;
   logic                     accept, pop, fifo_we;
   logic [CW-1:0]            credit_used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign sh_in[0] = in_sh0;
   assign sh_in[1] = in_sh1;
   assign sh_in[2] = in_sh2;
   assign sh_in[3] = in_sh3;

   assign out_valid   = (count_q != '0);
   assign pop         = out_valid & out_ready;
   assign fifo_we     = vpipe_q[SBOX_LAT-1];
   assign credit_used = CW'(count_q) + CW'(vpipe_q[0]) + CW'(vpipe_q[1]) - CW'(pop);
   assign accept      = RST_N & in_valid & rnd_valid & (credit_used < CW'(FIFO_DEPTH));
   assign in_ready    = accept;
   assign rnd_ready   = accept;

   // Everything entering the lanes is ANDed with accept so idle cycles carry no mask material.
   always_comb begin
      for (int k = 0; k < SBOX_SHARES; k++) sh_gated[k] = sh_in[k] & {W{accept}};
      rnd_gated = rnd & {(RND_W*NUM_LANES){accept}};
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : gen_lane
      share_byte_t lane_in  [SBOX_SHARES];
      share_byte_t lane_out [SBOX_SHARES];
      for (genvar k = 0; k < SBOX_SHARES; k++) begin : gen_share
         assign lane_in[k]                 = sh_gated[k][8*i +: 8];
         assign wr_entry[k*W + 8*i +: 8]   = lane_out[k];
      end
      masked_sbox_lane u_lane (
         .clk_i (CLK),
         .sh_i  (lane_in),
         .rnd_i (rnd_gated[RND_W*i +: RND_W]),
         .sh_o  (lane_out)
      );
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vpipe_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         // NOTE: FIFO storage is reset with the control state so no share survives RST_N.
         for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
      end else begin
         vpipe_q <= {vpipe_q[SBOX_LAT-2:0], accept};
         if (pop) begin
            rptr_q <= ptr_inc(rptr_q);
`ifdef OUT_ZEROIZE_EN
            mem_q[rptr_q] <= '0;
`endif
         end
         if (fifo_we) begin
            mem_q[wptr_q] <= wr_entry;
            wptr_q        <= ptr_inc(wptr_q);
         end
         count_q <= count_q + CNT_W'(fifo_we) - CNT_W'(pop);
      end
   end

   // While empty the slot behind the read pointer still holds the last popped entry.
   assign prev_ptr = (rptr_q == '0) ? PTR_W'(FIFO_DEPTH - 1) : rptr_q - 1'b1;

   always_comb begin
      out_entry = out_valid ? mem_q[rptr_q] : mem_q[prev_ptr];
`ifdef OUT_ZEROIZE_EN
      if (!out_valid) out_entry = '0;
`endif
   end

   assign out_sh0   = out_entry[0*W +: W];
   assign out_sh1   = out_entry[1*W +: W];
   assign out_sh2   = out_entry[2*W +: W];
   assign out_sh3   = out_entry[3*W +: W];
   assign occupancy = count_q + CNT_W'(vpipe_q[0]) + CNT_W'(vpipe_q[1]);
   assign busy      = (occupancy != '0);

   a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N)
      fifo_we |-> (count_q != CNT_W'(FIFO_DEPTH)));

endmodule
